// File: rtl/odd_pipe_issue_ctrl.sv
// odd_pipe_issue_ctrl
// In-order issue controller for the SPU odd pipe (permute, load/store, branch).
// A DEPTH-stage scoreboard mirrors the odd-pipe forwarding stages. It stalls
// issue on RAW hazards until the producer reaches its forwarding stage, blocks
// issue in the branch shadow, pulses flush on taken branches, and drives
// register-file writeback timing from the last stage.
//
// Optional build feature: define ODD_ISSUE_PERF_EN to add the saturating
// stall_cycles (32 bit) and flush_count (16 bit) performance counters.
`timescale 1ns/1ps

module odd_pipe_issue_ctrl #(
   parameter int DEPTH      = 7,
   parameter int LAT_PERM   = 4,
   parameter int LAT_LOAD   = 6,
   parameter int LAT_LINK   = 2,
   parameter int BR_TIMEOUT = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_class,
   input  logic [6:0] in_ra_addr,
   input  logic       in_ra_used,
   input  logic [6:0] in_rb_addr,
   input  logic       in_rb_used,
   input  logic [6:0] in_rt_addr,
   input  logic       in_rt_wr,
   output logic       issue_valid,
   output logic [1:0] issue_class,
   output logic [6:0] issue_rt_addr,
   input  logic       branch_resolved,
   input  logic       branch_taken,
   output logic       flush,
   output logic       wb_valid,
   output logic [6:0] wb_rt_addr,
   output logic       br_timeout
`ifdef ODD_ISSUE_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   localparam int LAT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      CLS_PERM   = 2'd0,
      CLS_LOAD   = 2'd1,
      CLS_STORE  = 2'd2,
      CLS_BRANCH = 2'd3
   } cls_t;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BR_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   // One in-flight instruction as it travels down the odd pipe.
   typedef struct packed {
      logic             valid;
      logic             rt_wr;
      logic [6:0]       rt;
      logic [LAT_W-1:0] lat;
      logic [1:0]       cls;
   } sb_entry_t;

   sb_entry_t        sb [1:DEPTH];
   sb_entry_t        new_entry;
   state_t           state;
   state_t           state_next;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_next;
   logic             hazard;
   logic             accept;

   assign accept = in_valid && in_ready;

   // Build the stage-1 entry for the instruction being accepted this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      new_entry = '0;
      if (accept) begin
         new_entry.valid = 1'b1;
         new_entry.rt    = in_rt_addr;
         new_entry.cls   = in_class;
         case (cls_t'(in_class))
            CLS_PERM: begin
               new_entry.rt_wr = in_rt_wr;
               new_entry.lat   = LAT_W'(LAT_PERM);
            end
            CLS_LOAD: begin
               new_entry.rt_wr = in_rt_wr;
               new_entry.lat   = LAT_W'(LAT_LOAD);
            end
            CLS_BRANCH: begin
               new_entry.rt_wr = in_rt_wr;
               new_entry.lat   = LAT_W'(LAT_LINK);
            end
            default: begin
               // Stores never produce a register result.
               new_entry.rt_wr = 1'b0;
               new_entry.lat   = '0;
            end
         endcase
      end
   end

   // Scoreboard shift register: stage 1 takes the new entry, stage DEPTH retires.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the scoreboard is a flop array, not a RAM, and every stage is cleared so no stale entry can raise a hazard after reset.
         for (int k = 1; k <= DEPTH; k++) begin
            sb[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage read its neighbour's old value, giving a true shift.
         sb[1] <= new_entry;
         for (int k = 2; k <= DEPTH; k++) begin
            sb[k] <= sb[k-1];
         end
      end
   end

   // RAW hazard: a writing entry that has not yet reached its forwarding stage.
   always_comb begin
      hazard = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (sb[k].valid && sb[k].rt_wr && (k < int'(sb[k].lat)) &&
             ((in_ra_used && (sb[k].rt == in_ra_addr)) ||
              (in_rb_used && (sb[k].rt == in_rb_addr)))) begin
            hazard = 1'b1;
         end
      end
   end

   // Ready is forced low while reset is asserted, independent of FSM state.
   assign in_ready = reset && (state == ST_RUN) && !hazard;

   assign issue_valid   = sb[1].valid;
   assign issue_class   = sb[1].cls;
   assign issue_rt_addr = sb[1].rt;

   assign wb_valid   = sb[DEPTH].valid && sb[DEPTH].rt_wr;
   assign wb_rt_addr = wb_valid ? sb[DEPTH].rt : 7'd0;

   // Branch-shadow FSM state and wait timer registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   // Branch-shadow FSM next state, flush and timeout pulses.
   always_comb begin
      state_next = state;
      timer_next = timer;
      flush      = 1'b0;
      br_timeout = 1'b0;
      case (state)
         ST_RUN: begin
            timer_next = '0;
            if (accept && (cls_t'(in_class) == CLS_BRANCH)) begin
               state_next = ST_BR_WAIT;
            end
         end
         ST_BR_WAIT: begin
            if (branch_resolved) begin
               timer_next = '0;
               state_next = branch_taken ? ST_FLUSH : ST_RUN;
            end else if (timer == TMR_W'(BR_TIMEOUT - 1)) begin
               // No outcome arrived in time: resume as if not taken.
               timer_next = '0;
               br_timeout = 1'b1;
               state_next = ST_RUN;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         ST_FLUSH: begin
            flush      = 1'b1;
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
            timer_next = '0;
         end
      endcase
   end

`ifdef ODD_ISSUE_PERF_EN
   // Saturating counters of stalled request cycles and flush pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (in_valid && !in_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (flush && (flush_count != '1)) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_odd_pipe_issue_ctrl.sv
// tb_odd_pipe_issue_ctrl
// Self-checking bench: a vector table for the forwarding-latency case, hand
// sequences for stalls, branches, timeout and reset, then random traffic
// checked against an age-based model of in-flight instructions.
`timescale 1ns/1ps

module tb_odd_pipe_issue_ctrl;

   localparam int DEPTH      = 7;
   localparam int BR_TIMEOUT = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_class;
   logic [6:0] in_ra_addr;
   logic       in_ra_used;
   logic [6:0] in_rb_addr;
   logic       in_rb_used;
   logic [6:0] in_rt_addr;
   logic       in_rt_wr;
   logic       issue_valid;
   logic [1:0] issue_class;
   logic [6:0] issue_rt_addr;
   logic       branch_resolved;
   logic       branch_taken;
   logic       flush;
   logic       wb_valid;
   logic [6:0] wb_rt_addr;
   logic       br_timeout;
`ifdef ODD_ISSUE_PERF_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   always #5 clock = ~clock;

   odd_pipe_issue_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_class        (in_class),
      .in_ra_addr      (in_ra_addr),
      .in_ra_used      (in_ra_used),
      .in_rb_addr      (in_rb_addr),
      .in_rb_used      (in_rb_used),
      .in_rt_addr      (in_rt_addr),
      .in_rt_wr        (in_rt_wr),
      .issue_valid     (issue_valid),
      .issue_class     (issue_class),
      .issue_rt_addr   (issue_rt_addr),
      .branch_resolved (branch_resolved),
      .branch_taken    (branch_taken),
      .flush           (flush),
      .wb_valid        (wb_valid),
      .wb_rt_addr      (wb_rt_addr),
      .br_timeout      (br_timeout)
`ifdef ODD_ISSUE_PERF_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model: instructions tracked by age ----------
   typedef struct {
      int         cls;
      logic [6:0] rt;
      bit         rt_wr;
      int         acc;
   } inst_t;

   inst_t      fl[$];
   int         cyc        = 0;
   bit         br_pending = 0;
   int         br_acc     = 0;
   int         flush_cyc  = -1;
   int         m_stall    = 0;
   int         m_flush    = 0;
   int         wb_seen    = 0;
   bit         e_ready, e_issue, e_flush, e_wb, e_brto;
   int         e_cls;
   logic [6:0] e_irt, e_wbrt;

   function automatic int lat_of(input int c);
      case (c)
         0:       return 4;
         1:       return 6;
         3:       return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      fl.delete();
      br_pending = 0;
      flush_cyc  = -1;
      m_stall    = 0;
      m_flush    = 0;
   endtask

   task automatic model_eval();
      bit hz;
      hz      = 0;
      e_issue = 0;
      e_cls   = 0;
      e_irt   = '0;
      e_wb    = 0;
      e_wbrt  = '0;
      foreach (fl[i]) begin
         int age;
         age = cyc - fl[i].acc;
         if (age == 1) begin
            e_issue = 1;
            e_cls   = fl[i].cls;
            e_irt   = fl[i].rt;
         end
         if (age == DEPTH && fl[i].rt_wr) begin
            e_wb   = 1;
            e_wbrt = fl[i].rt;
         end
         if (fl[i].rt_wr && age < lat_of(fl[i].cls) &&
             ((in_ra_used && in_ra_addr == fl[i].rt) ||
              (in_rb_used && in_rb_addr == fl[i].rt)))
            hz = 1;
      end
      e_flush = (cyc == flush_cyc);
      e_brto  = br_pending && !branch_resolved && (cyc - br_acc == BR_TIMEOUT);
      e_ready = !br_pending && !e_flush && !hz;
   endtask

   task automatic model_update();
      if (br_pending) begin
         if (branch_resolved) begin
            br_pending = 0;
            if (branch_taken) flush_cyc = cyc + 1;
         end else if (e_brto) begin
            br_pending = 0;
         end
      end
      if (in_valid && !e_ready) m_stall++;
      if (e_flush) m_flush++;
      if (in_valid && e_ready) begin
         fl.push_back('{cls: int'(in_class), rt: in_rt_addr,
                        rt_wr: (in_rt_wr && in_class != 2'd2), acc: cyc});
         if (in_class == 2'd3) begin
            br_pending = 1;
            br_acc     = cyc;
         end
      end
      while (fl.size() > 0 && (cyc - fl[0].acc) >= DEPTH) void'(fl.pop_front());
      cyc++;
   endtask

   task automatic model_check();
      model_eval();
      check("in_ready",      in_ready,      e_ready);
      check("issue_valid",   issue_valid,   e_issue);
      check("issue_class",   issue_class,   32'(e_cls));
      check("issue_rt_addr", issue_rt_addr, e_irt);
      check("flush",         flush,         e_flush);
      check("wb_valid",      wb_valid,      e_wb);
      check("wb_rt_addr",    wb_rt_addr,    e_wbrt);
      check("br_timeout",    br_timeout,    e_brto);
      if (wb_valid) wb_seen++;
   endtask

   // ---------------- stimulus helpers ----------------------------------------
   // Inputs change at posedge+1, outputs are sampled at posedge+5.
   task automatic drive(input bit v, input int cls, input int ra, input bit rau,
                        input int rb, input bit rbu, input int rt, input bit rtw);
      in_valid   = v;
      in_class   = 2'(cls);
      in_ra_addr = 7'(ra);
      in_ra_used = rau;
      in_rb_addr = 7'(rb);
      in_rb_used = rbu;
      in_rt_addr = 7'(rt);
      in_rt_wr   = rtw;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      branch_resolved = 0;
      branch_taken    = 0;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic advance();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      model_check();
      advance();
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- vector table -------------------------------------------
   typedef struct {
      bit         v;
      int         cls;
      int         ra;
      bit         rau;
      int         rt;
      bit         rtw;
      bit         x_ready;
      bit         x_issue;
      bit         x_wb;
      logic [6:0] x_wbrt;
   } vec_t;

   function automatic vec_t mk(input bit v, input int cls, input int ra, input bit rau,
                               input int rt, input bit rtw, input bit xr, input bit xi,
                               input bit xw, input int xwr);
      vec_t r;
      r.v = v; r.cls = cls; r.ra = ra; r.rau = rau; r.rt = rt; r.rtw = rtw;
      r.x_ready = xr; r.x_issue = xi; r.x_wb = xw; r.x_wbrt = 7'(xwr);
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[12];
      int   n;
      int   iss;
      bit   got;

      // Permute rt=5 then a dependent permute: stalls until stage 4.
      tbl[0]  = mk(1, 0, 0, 0, 5, 1,  1, 0, 0, 0);
      tbl[1]  = mk(1, 0, 5, 1, 6, 1,  0, 1, 0, 0);
      tbl[2]  = mk(1, 0, 5, 1, 6, 1,  0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 5, 1, 6, 1,  0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 5, 1, 6, 1,  1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 5);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 6);

      // Reset state.
      idle();
      reset = 1'b0;
      #12;
      check("rst_in_ready",    in_ready,      0);
      check("rst_issue_valid", issue_valid,   0);
      check("rst_issue_class", issue_class,   0);
      check("rst_issue_rt",    issue_rt_addr, 0);
      check("rst_flush",       flush,         0);
      check("rst_wb_valid",    wb_valid,      0);
      check("rst_wb_rt",       wb_rt_addr,    0);
      check("rst_br_timeout",  br_timeout,    0);
      #11 reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;

      // Table-driven forwarding-latency case.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v, tbl[i].cls, tbl[i].ra, tbl[i].rau, 0, 0, tbl[i].rt, tbl[i].rtw);
         settle();
         model_check();
         check("tbl_ready", in_ready,    tbl[i].x_ready);
         check("tbl_issue", issue_valid, tbl[i].x_issue);
         check("tbl_wb",    wb_valid,    tbl[i].x_wb);
         check("tbl_wb_rt", wb_rt_addr,  tbl[i].x_wbrt);
         advance();
      end
      drain(4);

      // Load rt=9 then a store reading rb=9: five stall cycles, store never writes back.
      wb_seen = 0;
      drive(1, 1, 0, 0, 0, 0, 9, 1);
      step();
      drive(1, 2, 2, 1, 9, 1, 0, 0);
      n   = 0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (!got) begin
            settle();
            model_check();
            if (in_ready) got = 1;
            else n++;
            advance();
         end
      end
      check("ld_st_accepted", got, 1);
      check("ld_st_stalls",   n,   5);
      drain(10);
      check("ld_st_wb_count", wb_seen, 1);

      // Ten independent permutes issue back to back.
      iss = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 10) drive(1, 0, 40 + i, 1, 60, 1, 20 + i, 1);
         else idle();
         settle();
         model_check();
         if (i < 10) check("ind_ready", in_ready, 1);
         if (issue_valid) iss++;
         advance();
      end
      check("ind_issue_run", iss, 10);
      drain(8);

      // Branch resolved taken three cycles after acceptance.
      drive(1, 3, 0, 0, 0, 0, 0, 0);
      step();
      idle();
      for (int i = 1; i <= 5; i++) begin
         branch_resolved = (i == 3);
         branch_taken    = (i == 3);
         settle();
         model_check();
         check("brt_ready", in_ready, (i == 5));
         check("brt_flush", flush,    (i == 4));
         advance();
      end
      drain(8);

      // Branch with no resolution: timeout after 8 cycles, no flush.
      drive(1, 3, 0, 0, 0, 0, 0, 0);
      step();
      idle();
      for (int i = 1; i <= 9; i++) begin
         settle();
         model_check();
         check("bto_pulse", br_timeout, (i == 8));
         check("bto_flush", flush,      0);
         check("bto_ready", in_ready,   (i == 9));
         advance();
      end
      drain(8);

      // Reset asserted mid-stall with an issue and a writeback in flight.
      drive(1, 0, 0, 0, 0, 0, 3, 1);
      step();
      drain(5);
      drive(1, 1, 0, 0, 0, 0, 9, 1);
      step();
      drive(1, 2, 0, 0, 9, 1, 0, 0);
      settle();
      model_check();
      #2 reset = 1'b0;
      #1;
      check("mid_rst_ready", in_ready,    0);
      check("mid_rst_issue", issue_valid, 0);
      check("mid_rst_wb",    wb_valid,    0);
      check("mid_rst_flush", flush,       0);
      model_reset();
      @(posedge clock);
      #3 reset = 1'b1;
      #2;
      model_check();
      check("post_rst_ready", in_ready, 1);
      advance();
      drain(10);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         int r;
         int c;
         r = $urandom_range(0, 9);
         c = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
         drive(($urandom_range(0, 3) != 0), c,
               $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
               $urandom_range(0, 7), ($urandom_range(0, 1) != 0),
               $urandom_range(0, 7),
               (c == 2) ? 1'b0 : (c == 3) ? ($urandom_range(0, 1) != 0) : 1'b1);
         branch_resolved = ($urandom_range(0, 4) == 0);
         branch_taken    = ($urandom_range(0, 1) != 0);
         step();
      end
      drain(12);

`ifdef ODD_ISSUE_PERF_EN
      check("perf_stall_cycles", stall_cycles, m_stall);
      check("perf_flush_count",  flush_count,  m_flush);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/odd_pipe_issue_ctrl.md
Name: odd_pipe_issue_ctrl

Overview:
- In-order issue controller for the SPU odd pipe (permute, load/store, branch).
- Accepts one decoded odd-pipe instruction per cycle and tracks in-flight destinations in a 7-stage scoreboard mirroring fw_op_st_1..7.
- Stalls on RAW hazards until the producer reaches its forwarding stage, blocks issue in the branch shadow, and flushes on taken branches.
- Drives writeback-enable timing to the register file.

Parameters:
- DEPTH, 7, odd-pipe stages tracked (stage 1..DEPTH).
- LAT_PERM, 4, stage at which a permute/shift/rotate/gather result is forwardable.
- LAT_LOAD, 6, stage at which a load result is forwardable.
- LAT_LINK, 2, stage at which a branch-and-set-link result is forwardable.
- BR_TIMEOUT, 8, max cycles in BR_WAIT before forced resume.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- in_valid  in  1  decoded instruction present
- in_ready  out  1  controller can accept this cycle
- in_class  in  2  0 permute, 1 load, 2 store, 3 branch
- in_ra_addr  in  7  source A register
- in_ra_used  in  1  source A is read
- in_rb_addr  in  7  source B register (store data / shift count)
- in_rb_used  in  1  source B is read
- in_rt_addr  in  7  destination register
- in_rt_wr  in  1  instruction writes rt (load, permute, set-link branch)
- issue_valid  out  1  registered issue strobe to odd pipe
- issue_class  out  2  class of issued instruction
- issue_rt_addr  out  7  destination of issued instruction
- branch_resolved  in  1  odd pipe branch outcome valid
- branch_taken  in  1  outcome, qualified by branch_resolved
- flush  out  1  one-cycle pulse: discard fetched/decoded instructions
- wb_valid  out  1  entry at stage DEPTH writes the register file
- wb_rt_addr  out  7  destination for wb_valid
- br_timeout  out  1  one-cycle pulse on BR_WAIT timeout

Behaviour:
- Reset (reset=0, async): scoreboard entries invalid; FSM=RUN; timer=0. All outputs 0, including in_ready.
- Accept: in_valid && in_ready at edge t. Next cycle, issue_valid=1 with class/rt, and the entry is written to stage 1 as {valid, rt_wr, rt, lat}. lat is LAT_PERM for class 0, LAT_LOAD for class 1, LAT_LINK for class 3, and unused for stores (rt_wr=0).
- Scoreboard shifts one stage per cycle. An entry at stage DEPTH with rt_wr drives wb_valid=1 and wb_rt_addr, then retires.
- Hazard: any valid entry with rt_wr, stage k < lat, and rt equal to a used source (ra or rb).
- in_ready = (state==RUN) && !hazard. Stores are hazard-checked on both ra and rb.
- Entries past their lat never stall; forwarding is the odd pipe's responsibility.
- FSM:
  - RUN: accepting a branch moves to BR_WAIT.
  - BR_WAIT: in_ready=0; timer increments. On branch_resolved: taken → FLUSH, not taken → RUN. On timer==BR_TIMEOUT-1 with no resolution → br_timeout pulse and RUN (treated as not taken).
  - FLUSH: flush=1 for exactly one cycle, in_ready=0, then RUN.
- branch_resolved outside BR_WAIT is ignored.
- Taken branch: no younger entries exist because of the branch shadow; scoreboard entries are not killed.
- Reset mid-BR_WAIT or mid-stall: immediate return to reset state; no flush pulse.
- Simultaneous retire and issue: normal shift; no conflict.
- Duplicate rt in flight: each entry is checked independently; any unmet one stalls.

Optional Feature:
- Macro: ODD_ISSUE_PERF_EN.
- When defined, adds outputs stall_cycles (32 bits) and flush_count (16 bits), both cleared by reset.
  - stall_cycles counts cycles with in_valid && !in_ready; saturates at all-ones.
  - flush_count counts flush pulses; saturates at all-ones.
- When undefined, these ports and counters are absent.

Test Plan:
- Permute rt=5 accepted at cycle 0, then a dependent permute with ra=5 held valid → in_ready=0 for cycles 1–3, accepted at cycle 4 (producer at stage 4); wb_valid with wb_rt_addr=5 at cycle 7.
- Load rt=9 followed by a store with rb=9 → store stalls 5 cycles, accepted when the load is at stage 6; the store produces no wb_valid.
- Independent stream of 10 permutes with distinct rt and no shared sources → accepted every cycle; issue_valid high for 10 consecutive cycles.
- Branch accepted; branch_resolved=1, branch_taken=1 three cycles later → in_ready=0 while waiting; flush=1 for one cycle; in_ready returns the following cycle.
- Branch with no resolution → br_timeout pulse after 8 cycles in BR_WAIT, flush stays 0, issue resumes.
- Reset driven low mid-stall, asynchronously between edges → in_ready, issue_valid, wb_valid and flush drop to 0 immediately; after release, the first instruction issues with no stale hazard.
